// File: rtl/noc_params.sv
// Shared NoC parameters, flit label encoding and flit bundle.
// Used by the network-interface packetizer and its credit counters.
package noc_params;

    localparam int VC_NUM           = 2;
    localparam int VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int BUFFER_SIZE      = 8;
    localparam int CREDIT_W         = $clog2(BUFFER_SIZE + 1);
    localparam int MESH_SIZE_X      = 5;
    localparam int MESH_SIZE_Y      = 5;
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int FLIT_DATA_SIZE   = 16;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEADTAIL
    } flit_label_t;

    typedef struct packed {
        flit_label_t                flit_label;
        logic [VC_SIZE-1:0]         vc_id;
        logic [FLIT_DATA_SIZE-1:0]  data;
    } flit_t;

endpackage

// File: rtl/ni_credit_counter.sv
// Per-VC downstream credit counter, range 0..BUFFER_SIZE.
// Send and return in the same cycle cancel; returns saturate at full.
module ni_credit_counter
    import noc_params::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                dec,
    input  logic                inc,
    output logic                has_credit,
    output logic [CREDIT_W-1:0] count
);

    localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(BUFFER_SIZE);

    // credit register: load full on reset, track sends and returns
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= FULL;
        end else if (dec && !inc) begin
            count <= count - CREDIT_W'(1);
        end else if (inc && !dec && count != FULL) begin
            count <= count + CREDIT_W'(1);
        end
    end

    // a return into an already-full counter means the downstream lied
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(inc && !dec && count == FULL));
        end
    end

    assign has_credit = (count != '0);

endmodule

// File: rtl/ni_packetizer.sv
// NI transmitter: request + payload stream -> head/body/tail flits, per-VC credits.
// Optional NI_DEST_CHECK_EN: off-mesh destinations loop back locally, flagged on dest_err_o.
module ni_packetizer
    import noc_params::*;
#(
    parameter int X_CURRENT      = 0,
    parameter int Y_CURRENT      = 0,
    parameter int MAX_PACKET_LEN = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       pkt_valid_i,
    output logic                                       pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]                x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]                y_dest_i,
    input  logic [$clog2(MAX_PACKET_LEN+1)-1:0]        pkt_len_i,
    input  logic [FLIT_DATA_SIZE-1:0]                  payload_data_i,
    input  logic                                       payload_valid_i,
    output logic                                       payload_ready_o,
    output flit_t                                      flit_o,
    output logic                                       valid_flit_o,
    input  logic [VC_NUM-1:0]                          credit_i,
    output logic                                       busy_o
`ifdef NI_DEST_CHECK_EN
    ,output logic                                      dest_err_o
`endif
);

    localparam int LEN_W = $clog2(MAX_PACKET_LEN + 1);
    localparam int PAD_W = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

    state_t                      state_q, state_d;
    logic [VC_SIZE-1:0]          vc_q, vc_d, rr_q, rr_d, sel_vc;
    logic                        sel_found;
    logic [DEST_ADDR_SIZE_X-1:0] x_q, x_d, x_in;
    logic [DEST_ADDR_SIZE_Y-1:0] y_q, y_d, y_in;
    logic [LEN_W-1:0]            len_q, len_d, rem_q, rem_d, len_in;
    logic [VC_NUM-1:0]           has_credit, dec;
    logic [CREDIT_W-1:0]         credit [VC_NUM];

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        ni_credit_counter u_cc (
            .clk        (clk),
            .rst        (rst),
            .dec        (dec[v]),
            .inc        (credit_i[v]),
            .has_credit (has_credit[v]),
            .count      (credit[v])
        );
    end

    assign len_in = (pkt_len_i == '0) ? LEN_W'(1) : pkt_len_i;

`ifdef NI_DEST_CHECK_EN
    logic dest_bad;

    assign dest_bad = ({1'b0, x_dest_i} >= (DEST_ADDR_SIZE_X+1)'(MESH_SIZE_X)) ||
                      ({1'b0, y_dest_i} >= (DEST_ADDR_SIZE_Y+1)'(MESH_SIZE_Y));
    assign x_in = dest_bad ? DEST_ADDR_SIZE_X'(X_CURRENT) : x_dest_i;
    assign y_in = dest_bad ? DEST_ADDR_SIZE_Y'(Y_CURRENT) : y_dest_i;

    // sticky error flag, set on any accepted off-mesh request
    always_ff @(posedge clk) begin
        if (rst) begin
            dest_err_o <= 1'b0;
        end else if (pkt_valid_i && pkt_ready_o && dest_bad) begin
            dest_err_o <= 1'b1;
        end
    end
`else
    assign x_in = x_dest_i;
    assign y_in = y_dest_i;
`endif

    // round-robin VC pick: lowest offset from rr_q with credit wins
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_vc    = '0;
        for (int i = VC_NUM - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= VC_NUM) idx = idx - VC_NUM;
            if (has_credit[idx]) begin
                sel_found = 1'b1;
                sel_vc    = VC_SIZE'(idx);
            end
        end
    end

    // next-state and flit build; everything is quiet while rst is held
    always_comb begin
        state_d         = state_q;
        vc_d            = vc_q;
        rr_d            = rr_q;
        x_d             = x_q;
        y_d             = y_q;
        len_d           = len_q;
        rem_d           = rem_q;
        pkt_ready_o     = 1'b0;
        payload_ready_o = 1'b0;
        valid_flit_o    = 1'b0;
        flit_o          = '0;
        dec             = '0;
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    pkt_ready_o = 1'b1;
                    if (pkt_valid_i) begin
                        x_d     = x_in;
                        y_d     = y_in;
                        len_d   = len_in;
                        rem_d   = len_in;
                        state_d = S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (sel_found) begin
                        valid_flit_o      = 1'b1;
                        flit_o.flit_label = (len_q == LEN_W'(1)) ? HEADTAIL : HEAD;
                        flit_o.vc_id      = sel_vc;
                        flit_o.data       = {x_q, y_q, {PAD_W{1'b0}}};
                        dec[sel_vc]       = 1'b1;
                        vc_d              = sel_vc;
                        rr_d              = (sel_vc == VC_SIZE'(VC_NUM - 1)) ?
                                            '0 : sel_vc + VC_SIZE'(1);
                        state_d           = (len_q == LEN_W'(1)) ? S_IDLE : S_BODY;
                    end
                end
                S_BODY: begin
                    payload_ready_o = (credit[vc_q] != '0);
                    if (payload_valid_i && payload_ready_o) begin
                        valid_flit_o      = 1'b1;
                        flit_o.flit_label = (rem_q == LEN_W'(2)) ? TAIL : BODY;
                        flit_o.vc_id      = vc_q;
                        flit_o.data       = payload_data_i;
                        dec[vc_q]         = 1'b1;
                        rem_d             = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(2)) state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // state and latched request registers; reset drops any packet in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vc_q    <= '0;
            rr_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            len_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            vc_q    <= vc_d;
            rr_q    <= rr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: flit-stream model with per-cycle compare.
// Directed packets cover latency, RR VC choice, credit exhaustion, bubbles, reset.
module tb_ni_packetizer;
    import noc_params::*;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        pkt_valid_i = 1'b0;
    logic                        pkt_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest_i = '0;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest_i = '0;
    logic [3:0]                  pkt_len_i = '0;
    logic [FLIT_DATA_SIZE-1:0]   payload_data_i = '0;
    logic                        payload_valid_i = 1'b0;
    logic                        payload_ready_o;
    flit_t                       flit_o;
    logic                        valid_flit_o;
    logic [VC_NUM-1:0]           credit_i = '0;
    logic                        busy_o;
`ifdef NI_DEST_CHECK_EN
    logic                        dest_err_o;
`endif

    ni_packetizer #(
        .X_CURRENT      (2),
        .Y_CURRENT      (2),
        .MAX_PACKET_LEN (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pkt_valid_i     (pkt_valid_i),
        .pkt_ready_o     (pkt_ready_o),
        .x_dest_i        (x_dest_i),
        .y_dest_i        (y_dest_i),
        .pkt_len_i       (pkt_len_i),
        .payload_data_i  (payload_data_i),
        .payload_valid_i (payload_valid_i),
        .payload_ready_o (payload_ready_o),
        .flit_o          (flit_o),
        .valid_flit_o    (valid_flit_o),
        .credit_i        (credit_i),
        .busy_o          (busy_o)
`ifdef NI_DEST_CHECK_EN
        ,.dest_err_o     (dest_err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        flit_label_t   label;
        logic [15:0]   data;
        bit            head;
    } exp_t;

    exp_t  exp_q[$];
    flit_t cap_q[$];
    int    cap_t[$];
    int    m_credit [VC_NUM];
    int    m_rr = 0;
    int    m_vc = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] head_data(input int x, input int y);
        int xx;
        int yy;
        xx = x;
        yy = y;
`ifdef NI_DEST_CHECK_EN
        if (x >= MESH_SIZE_X || y >= MESH_SIZE_Y) begin
            xx = 2;
            yy = 2;
        end
`endif
        return {xx[2:0], yy[2:0], 10'b0};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // flit-stream model: expected flits in order, VC chosen round-robin by credit
    always @(negedge clk) begin
        int idx;
        bit found;
        exp_t e;
        if (rst) begin
            chk("rst_valid", 32'(valid_flit_o), 32'd0);
            chk("rst_flit", 32'(flit_o), 32'd0);
            chk("rst_pkt_ready", 32'(pkt_ready_o), 32'd0);
            chk("rst_payload_ready", 32'(payload_ready_o), 32'd0);
            for (int v = 0; v < VC_NUM; v++) m_credit[v] = BUFFER_SIZE;
            m_rr = 0;
            exp_q.delete();
        end else begin
            for (int v = 0; v < VC_NUM; v++)
                chk($sformatf("credit%0d", v), 32'(dut.credit[v]), 32'(m_credit[v]));
            if (valid_flit_o) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_flit");
                end else begin
                    e = exp_q.pop_front();
                    if (e.head) begin
                        found = 0;
                        for (int i = 0; i < VC_NUM; i++) begin
                            idx = (m_rr + i) % VC_NUM;
                            if (!found && m_credit[idx] > 0) begin
                                found = 1;
                                m_vc = idx;
                            end
                        end
                        if (!found) fail_now("head_without_credit");
                        m_rr = (m_vc + 1) % VC_NUM;
                    end else begin
                        chk("body_handshake", 32'(payload_valid_i && payload_ready_o), 32'd1);
                    end
                    chk("label", 32'(flit_o.flit_label), 32'(e.label));
                    chk("data", 32'(flit_o.data), 32'(e.data));
                    chk("vc_id", 32'(flit_o.vc_id), 32'(m_vc));
                    m_credit[m_vc] = m_credit[m_vc] - 1;
                    cap_q.push_back(flit_o);
                    cap_t.push_back(cyc);
                end
            end
            for (int v = 0; v < VC_NUM; v++)
                if (credit_i[v] && m_credit[v] < BUFFER_SIZE) m_credit[v]++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pkt_valid_i = 1'b0;
        payload_valid_i = 1'b0;
        credit_i = '0;
        step();
        step();
        rst = 1'b0;
        cap_q.delete();
        cap_t.delete();
    endtask

    task automatic request(input int x, input int y, input int len, input logic [15:0] pl [8]);
        int n;
        int t;
        bit ok;
        exp_t e;
        n = (len == 0) ? 1 : len;
        e.head = 1;
        e.label = (n == 1) ? HEADTAIL : HEAD;
        e.data = head_data(x, y);
        exp_q.push_back(e);
        for (int k = 1; k < n; k++) begin
            e.head = 0;
            e.label = (k == n - 1) ? TAIL : BODY;
            e.data = pl[k-1];
            exp_q.push_back(e);
        end
        pkt_valid_i = 1'b1;
        x_dest_i = 3'(x);
        y_dest_i = 3'(y);
        pkt_len_i = 4'(len);
        t = 0;
        ok = 0;
        while (t < 40 && !ok) begin
            @(negedge clk);
            ok = pkt_valid_i && pkt_ready_o;
            if (ok) acc_cyc = cyc;
            step();
            t++;
        end
        pkt_valid_i = 1'b0;
        if (!ok) fail_now("request_timeout");
    endtask

    task automatic stream(input int n, input logic [15:0] pl [8], input int gap_at, input int gap_len);
        int t;
        bit ok;
        for (int k = 0; k < n - 1; k++) begin
            if (k == gap_at) begin
                payload_valid_i = 1'b0;
                repeat (gap_len) step();
            end
            payload_valid_i = 1'b1;
            payload_data_i = pl[k];
            t = 0;
            ok = 0;
            while (t < 40 && !ok) begin
                @(negedge clk);
                ok = payload_valid_i && payload_ready_o;
                step();
                t++;
            end
            payload_valid_i = 1'b0;
            if (!ok) fail_now("payload_timeout");
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_o && t < 40) begin
            step();
            t++;
        end
        if (busy_o) fail_now("busy_timeout");
    endtask

    task automatic send_pkt(input int x, input int y, input int len, input logic [15:0] pl [8],
                            input int gap_at, input int gap_len);
        request(x, y, len, pl);
        stream((len == 0) ? 1 : len, pl, gap_at, gap_len);
        wait_idle();
    endtask

    logic [15:0] pl [8];
    logic [15:0] none [8];

    initial begin
        for (int i = 0; i < 8; i++) none[i] = '0;
        do_reset();

        // 1: single-flit packet, latency 1, credit consumed
        send_pkt(3, 1, 1, none, -1, 0);
        chk("t1_nflits", 32'(cap_q.size()), 32'd1);
        chk("t1_flit", 32'(cap_q[0]), {13'b0, HEADTAIL, 1'b0, 16'h6400});
        chk("t1_latency", 32'(cap_t[0] - acc_cyc), 32'd1);
        chk("t1_credit0", 32'(dut.credit[0]), 32'd7);
        chk("t1_busy", 32'(busy_o), 32'd0);
        send_pkt(1, 2, 0, none, -1, 0);
        chk("t1_len0_label", 32'(cap_q[1].flit_label), 32'(HEADTAIL));
        chk("t1_len0_vc", 32'(cap_q[1].vc_id), 32'd1);

        // 2: four-flit packet then RR moves to vc 1
        do_reset();
        pl = none;
        pl[0] = 16'hA;
        pl[1] = 16'hB;
        pl[2] = 16'hC;
        send_pkt(4, 4, 4, pl, -1, 0);
        chk("t2_nflits", 32'(cap_q.size()), 32'd4);
        chk("t2_head", 32'(cap_q[0]), {13'b0, HEAD, 1'b0, 16'h9000});
        chk("t2_body1", 32'(cap_q[1]), {13'b0, BODY, 1'b0, 16'h000A});
        chk("t2_body2", 32'(cap_q[2]), {13'b0, BODY, 1'b0, 16'h000B});
        chk("t2_tail", 32'(cap_q[3]), {13'b0, TAIL, 1'b0, 16'h000C});
        send_pkt(0, 0, 1, none, -1, 0);
        chk("t2_next_vc", 32'(cap_q[4].vc_id), 32'd1);

        // 3: exhaust credits, stall in HEAD, release one credit on vc 1
        do_reset();
        for (int i = 0; i < 8; i++) send_pkt(1, 1, 1, none, -1, 0);
        @(negedge clk);
        chk("t3_credit0_half", 32'(dut.credit[0]), 32'd4);
        chk("t3_credit1_half", 32'(dut.credit[1]), 32'd4);
        step();
        for (int i = 0; i < 8; i++) send_pkt(2, 3, 1, none, -1, 0);
        @(negedge clk);
        chk("t3_credit0_zero", 32'(dut.credit[0]), 32'd0);
        chk("t3_credit1_zero", 32'(dut.credit[1]), 32'd0);
        chk("t3_alt_vc", 32'(cap_q[5].vc_id), 32'd1);
        step();
        request(2, 2, 1, none);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_valid", 32'(valid_flit_o), 32'd0);
            chk("t3_stall_busy", 32'(busy_o), 32'd1);
            step();
        end
        credit_i = 2'b10;
        step();
        credit_i = 2'b00;
        wait_idle();
        chk("t3_nflits", 32'(cap_q.size()), 32'd17);
        chk("t3_release_vc", 32'(cap_q[16].vc_id), 32'd1);

        // 4: two-cycle payload gap between BODY and TAIL
        do_reset();
        pl = none;
        pl[0] = 16'h1234;
        pl[1] = 16'h5678;
        send_pkt(1, 0, 3, pl, 1, 2);
        chk("t4_nflits", 32'(cap_q.size()), 32'd3);
        chk("t4_body", 32'(cap_q[1].flit_label), 32'(BODY));
        chk("t4_tail", 32'(cap_q[2]), {13'b0, TAIL, 1'b0, 16'h5678});
        chk("t4_gap", 32'(cap_t[2] - cap_t[1]), 32'd3);

        // 5: reset in the middle of a five-flit packet
        do_reset();
        pl = none;
        for (int i = 0; i < 4; i++) pl[i] = 16'(16'h100 + i);
        send_pkt(0, 0, 1, none, -1, 0);
        request(3, 3, 5, pl);
        stream(3, pl, -1, 0);
        chk("t5_midpkt_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_valid", 32'(valid_flit_o), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_credit0", 32'(dut.credit[0]), 32'(BUFFER_SIZE));
        chk("t5_credit1", 32'(dut.credit[1]), 32'(BUFFER_SIZE));
        step();
        cap_q.delete();
        cap_t.delete();
        send_pkt(4, 0, 1, none, -1, 0);
        chk("t5_fresh_vc", 32'(cap_q[0].vc_id), 32'd0);
        chk("t5_fresh_data", 32'(cap_q[0].data), 32'h8000);

        // 6: off-mesh destination
        do_reset();
        send_pkt(7, 2, 1, none, -1, 0);
`ifdef NI_DEST_CHECK_EN
        chk("t6_loopback", 32'(cap_q[0].data), 32'h4800);
        chk("t6_err", 32'(dest_err_o), 32'd1);
        send_pkt(1, 1, 1, none, -1, 0);
        chk("t6_err_sticky", 32'(dest_err_o), 32'd1);
`else
        chk("t6_forward", 32'(cap_q[0].data), 32'hE800);
`endif

        step();
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
